// File: rtl/serial_logic_unit.sv
// Serial bitwise logic unit: applies AND/OR/XOR/XNOR to two operands CHUNK bits per cycle, LSB first.
// Optional feature macro: SLU_PARITY_EN adds the parity output (XOR-reduction of the completed result).
module serial_logic_unit #(
  parameter int WIDTH = 6,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef SLU_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] x_p0, y_p0;
  logic [1:0]       op_p0;
  logic [WIDTH-1:0] result_nxt;
  logic             accept;
  logic             last_chunk;
  int               base;

  function automatic logic [CHUNK-1:0] apply_op(input logic [1:0] o,
                                                input logic [CHUNK-1:0] a,
                                                input logic [CHUNK-1:0] b);
    case (o)
      2'b00:   apply_op = a & b;
      2'b01:   apply_op = a | b;
      2'b10:   apply_op = a ^ b;
      default: apply_op = ~(a ^ b);
    endcase
  endfunction

  assign last_chunk = (cnt == LAST);
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN:     if (last_chunk) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next result: current chunk replaced with the operation on the latched operand bits
  always_comb begin
    base       = int'(cnt) * CHUNK;
    result_nxt = result;
    result_nxt[base +: CHUNK] = apply_op(op_p0, x_p0[base +: CHUNK], y_p0[base +: CHUNK]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      x_p0   <= '0;
      y_p0   <= '0;
      op_p0  <= '0;
      result <= '0;
      zero   <= 1'b0;
`ifdef SLU_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        x_p0   <= x;
        y_p0   <= y;
        op_p0  <= op;
        result <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        result <= result_nxt;
        cnt    <= cnt + 1'b1;
        // Flags take the final value so they are valid together with done
        if (last_chunk) begin
          zero <= ~|result_nxt;
`ifdef SLU_PARITY_EN
          parity <= ^result_nxt;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed bench for serial_logic_unit with a scoreboard of expected completions.
module tb_serial_logic_unit;

  logic       clk = 1'b0;
  logic       rst_n, start, start_b;
  logic [1:0] op, op_b;
  logic [5:0] x, y, result;
  logic [7:0] x_b, y_b, result_b;
  logic       busy, done, zero, busy_b, done_b, zero_b;
`ifdef SLU_PARITY_EN
  logic       parity, parity_b;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0] res;
    logic       z;
    logic       p;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_logic_unit #(.WIDTH(6), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .x(x), .y(y),
    .busy(busy), .done(done), .result(result), .zero(zero)
`ifdef SLU_PARITY_EN
    , .parity(parity)
`endif
  );

  serial_logic_unit #(.WIDTH(8), .CHUNK(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .op(op_b), .x(x_b), .y(y_b),
    .busy(busy_b), .done(done_b), .result(result_b), .zero(zero_b)
`ifdef SLU_PARITY_EN
    , .parity(parity_b)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    e = sb.pop_front();
    check({tag, "_result"}, 32'(result), 32'(e.res));
    check({tag, "_zero"}, 32'(zero), 32'(e.z));
`ifdef SLU_PARITY_EN
    check({tag, "_parity"}, 32'(parity), 32'(e.p));
`endif
  endtask

  // One operation with start for a single cycle; inputs are scrambled after acceptance.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [5:0] a,
                       input logic [5:0] b, input logic [5:0] er, input logic ez,
                       input logic ep, input logic chk_part, input logic [5:0] part);
    int cyc;
    int bc;
    sb.push_back('{er, ez, ep});
    op = o; x = a; y = b; start = 1'b1;
    tick;
    start = 1'b0; op = ~o; x = ~a; y = ~b;
    cyc = 0; bc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) bc++;
      tick;
      cyc++;
      if (chk_part && cyc == 1) check({tag, "_partial"}, 32'(result), 32'(part));
    end
    check({tag, "_latency"}, cyc, 3);
    check({tag, "_busy_cycles"}, bc, 3);
    pop_check(tag);
    tick;
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_idle_busy"}, 32'(busy), 0);
    tick;
    check({tag, "_hold_result"}, 32'(result), 32'(er));
    check({tag, "_hold_zero"}, 32'(zero), 32'(ez));
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; x = '0; y = '0;
    start_b = 1'b0; op_b = 2'b00; x_b = '0; y_b = '0;
    tick; tick;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_zero", 32'(zero), 0);
    check("rst_b_result", 32'(result_b), 0);

    // Release reset and request start for the very first active edge
    rst_n = 1'b1;
    do_op("xor_alt", 2'b10, 6'b101010, 6'b010101, 6'b111111, 1'b0, 1'b0, 1'b0, 6'b0);
    do_op("and_mask", 2'b00, 6'b111111, 6'b000101, 6'b000101, 1'b0, 1'b0, 1'b1, 6'b000001);
    do_op("xor_same", 2'b10, 6'b100011, 6'b100011, 6'b000000, 1'b1, 1'b0, 1'b0, 6'b0);
    do_op("xnor_same", 2'b11, 6'b100011, 6'b100011, 6'b111111, 1'b0, 1'b0, 1'b0, 6'b0);

    // start held through RUN and DONE; x changes after acceptance
    sb.push_back('{6'b000011, 1'b0, 1'b0});
    op = 2'b01; x = 6'b000010; y = 6'b000011; start = 1'b1;
    tick;
    x = 6'b111111;
    tick; check("held_done_e1", 32'(done), 0);
    tick; check("held_done_e2", 32'(done), 0);
    tick; check("held_done_e3", 32'(done), 1);
    pop_check("held");
    sb.push_back('{6'b111111, 1'b0, 1'b0});
    tick;
    check("restart_busy", 32'(busy), 1);
    check("restart_done", 32'(done), 0);
    check("restart_cleared", 32'(result), 0);
    start = 1'b0;
    tick; tick; tick;
    check("restart_done_pulse", 32'(done), 1);
    pop_check("restart");
    tick;

    // Reset in the middle of RUN aborts the operation
    op = 2'b10; x = 6'b101010; y = 6'b010101; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    check("abort_partial", 32'(result), 32'(6'b001111));
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_result", 32'(result), 0);
    check("abort_done", 32'(done), 0);
    tick;
    check("abort_no_done", 32'(done), 0);
    rst_n = 1'b1;
    do_op("after_abort", 2'b00, 6'b110110, 6'b011011, 6'b010010, 1'b0, 1'b0, 1'b0, 6'b0);

    // Single-bit chunks on the 8-bit instance
    op_b = 2'b11; x_b = 8'hF0; y_b = 8'h0F; start_b = 1'b1;
    tick;
    start_b = 1'b0; x_b = 8'h00;
    cyc = 0;
    while (done_b !== 1'b1 && cyc < 40) begin
      tick;
      cyc++;
    end
    check("w8_latency", cyc, 8);
    check("w8_result", 32'(result_b), 0);
    check("w8_zero", 32'(zero_b), 1);
`ifdef SLU_PARITY_EN
    check("w8_parity", 32'(parity_b), 0);
`endif
    tick;
    check("w8_done_pulse", 32'(done_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_logic_unit.md
SERIAL_LOGIC_UNIT -- requirements
Module: serial_logic_unit

Interface
REQ-001 Parameter WIDTH, default 6, operand and result width in bits; SHALL be at least 1.
REQ-002 Parameter CHUNK, default 2, bits processed per cycle; SHALL divide WIDTH exactly; N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to begin an operation; sampled on the rising edge of clk.
REQ-006 op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 XNOR.
REQ-007 x  input  WIDTH  operand A.
REQ-008 y  input  WIDTH  operand B.
REQ-009 busy  output  1  high while chunks are being processed.
REQ-010 done  output  1  one-cycle pulse when result is complete.
REQ-011 result  output  WIDTH  bitwise result, registered.
REQ-012 zero  output  1  high when the completed result is all zeros; valid while done=1.
REQ-013 parity  output  1  XOR-reduction of the completed result; present only when PARITY_EN is defined.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE, with a chunk counter of width ceil(log2(N)), minimum 1.
REQ-015 In IDLE or DONE, start=1 SHALL latch x, y and op, clear result to 0, clear the counter, and enter RUN.
REQ-016 In RUN, each cycle SHALL write result[k*CHUNK +: CHUNK] = latched op applied to latched x and y bits at chunk k, with k counting up from 0 (LSB first).
REQ-017 After chunk N-1 is written, the FSM SHALL enter DONE; DONE SHALL last one cycle, then return to IDLE unless start=1.
REQ-018 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-019 Latency: if start is sampled at edge E0, done SHALL be high after edge EN and low after edge E(N+1).
REQ-020 start while in RUN SHALL be ignored; latched operands and op SHALL NOT change.
REQ-021 Changes on x, y or op after start is accepted SHALL NOT affect the result.
REQ-022 result SHALL hold its last value in IDLE until the next accepted start.
REQ-023 zero and parity SHALL be computed from the full registered result in DONE and hold in IDLE.
REQ-024 When N=1, RUN SHALL last exactly one cycle.

Reset
REQ-025 When rst_n=0, the FSM SHALL enter IDLE immediately; counter, latched operands, result, busy, done, zero and parity SHALL be 0.
REQ-026 Reset asserted during RUN SHALL abort the operation with no done pulse.
REQ-027 The first start SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-028 Macro SLU_PARITY_EN: when defined, the parity port and its logic SHALL be present as in REQ-013 and REQ-023.
REQ-029 When SLU_PARITY_EN is undefined, the parity port SHALL be absent and all other behaviour SHALL be identical.

Verification (WIDTH=6, CHUNK=2, N=3 unless stated)
REQ-030 XOR, x=101010, y=010101, start for one cycle -> busy high for 3 cycles, then done pulse, result=111111, zero=0, parity=0.
REQ-031 AND, x=111111, y=000101 -> result=000101 at done; result shows 000001 after the first RUN edge (partial, LSB chunk).
REQ-032 XOR, x=y=100011 -> result=000000, zero=1, parity=0; then XNOR on the same operands -> result=111111.
REQ-033 OR, x=000010, y=000011; start held high and x changed to 111111 during RUN -> result=000011, single done; start still high in DONE starts a new operation.
REQ-034 XOR started, rst_n pulsed low after the second RUN edge -> busy=0 and result=000000 immediately, no done; the next start completes normally.
REQ-035 WIDTH=8, CHUNK=1, XNOR, x=0xF0, y=0x0F -> done 8 cycles after start, result=0x00, zero=1.
